// File: rtl/ets_pkg.sv
// Shared state encoding and sizing helpers for the ETS capture-and-average stage.
package ets_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_SWEEP   = 3'd2,
      ST_GAP     = 3'd3,
      ST_DRAIN   = 3'd4,
      ST_READOUT = 3'd5
   } ets_state_t;

   function automatic int acc_w(input int data_w, input int avg_log2);
      return data_w + avg_log2;
   endfunction

   function automatic int idx_w(input int point_num);
      return $clog2(point_num);
   endfunction

endpackage

// File: rtl/ets_acc_ram.sv
// Per-point accumulator store: one write port, one read port with a registered read.
module ets_acc_ram
   import ets_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int W     = acc_w(12, 2),
   parameter int AW    = idx_w(256)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      rdata <= mem_q[raddr];
   end

endmodule

// File: rtl/ets_capture.sv
// Capture-and-average stage behind the ETS sequencer: accumulates 2^AVG_LOG2 sweeps
// per point in RAM, then streams the averaged record over valid/ready.
module ets_capture
   import ets_pkg::*;
#(
   parameter int DATA_W    = 12,
   parameter int POINT_NUM = 256,
   parameter int ADC_LAT   = 3,
   parameter int AVG_LOG2  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              seq_busy,
   input  logic              sp_en,
   input  logic [DATA_W-1:0] adc_data,
   output logic              armed,
   output logic              done,
   output logic              err,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output ets_state_t        dbg_state
);

   localparam int              AW       = acc_w(DATA_W, AVG_LOG2);
   localparam int              IW       = idx_w(POINT_NUM);
   localparam int              SW       = AVG_LOG2 + 1;
   localparam logic [IW:0]     PTS      = (IW+1)'(POINT_NUM);
   localparam logic [IW-1:0]   LAST_IDX = IW'(POINT_NUM - 1);
   localparam logic [SW-1:0]   SWEEPS   = SW'(1 << AVG_LOG2);

   ets_state_t        state_q, state_d;
   logic              busy_q, seq_rise, seq_fall;
   logic [IW:0]       issue_cnt_q, issue_cnt_d;
   logic [SW-1:0]     sweep_cnt_q, sweep_cnt_d;
   logic              err_q, err_d, done_q, done_d;
   logic              flush, push_sp;
   logic              dl_vld_q [ADC_LAT];
   logic [IW-1:0]     dl_idx_q [ADC_LAT];
   logic              wr_vld_q, wr_last;
   logic [IW-1:0]     wr_idx_q;
   logic [DATA_W-1:0] wr_smp_q;
   logic              ram_we;
   logic [IW-1:0]     ram_waddr, ram_raddr;
   logic [AW-1:0]     ram_wdata, ram_rdata;
   logic [IW:0]       rd_cnt_q, rd_cnt_d;
   logic              rd_issue, inflight_q, inflight_last_q, pop;
   logic [2:0]        occ;
   logic [DATA_W-1:0] fifo_data_q [2];
   logic              fifo_last_q [2];
   logic              wptr_q, rptr_q;
   logic [1:0]        cnt_q;
   logic [DATA_W-1:0] rd_word;

   assign seq_rise = seq_busy & ~busy_q;
   assign seq_fall = ~seq_busy & busy_q;
   assign push_sp  = (state_q == ST_SWEEP) && sp_en && (issue_cnt_q < PTS);
   assign wr_last  = wr_vld_q && (wr_idx_q == LAST_IDX);
   assign pop      = rd_valid && rd_ready;
   // Occupancy the skid buffer will have once the read in flight lands and this cycle's pop leaves.
   assign occ      = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
   assign rd_issue = (state_q == ST_READOUT) && (rd_cnt_q < PTS) && (occ <= 3'd1);

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q + {{IW{1'b0}}, push_sp};
      sweep_cnt_d = sweep_cnt_q;
      err_d       = err_q;
      done_d      = 1'b0;
      flush       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_ARMED;
               err_d       = 1'b0;
               sweep_cnt_d = '0;
            end
         end
         ST_ARMED, ST_GAP: begin
            if (seq_rise) begin
               state_d     = ST_SWEEP;
               issue_cnt_d = '0;
            end
         end
         ST_SWEEP: begin
            if (issue_cnt_d == PTS) begin
               state_d = ST_DRAIN;
            end else if (seq_fall) begin
               err_d   = 1'b1;
               flush   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (wr_last) begin
               sweep_cnt_d = sweep_cnt_q + 1'b1;
               state_d     = (sweep_cnt_d == SWEEPS) ? ST_READOUT : ST_GAP;
            end
         end
         ST_READOUT: begin
            if (pop && rd_last) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort) begin
         state_d     = ST_IDLE;
         flush       = 1'b1;
         done_d      = 1'b0;
         err_d       = err_q;
         sweep_cnt_d = sweep_cnt_q;
      end
      rd_cnt_d = (state_d == ST_READOUT) ? rd_cnt_q + {{IW{1'b0}}, rd_issue} : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         issue_cnt_q <= '0;
         sweep_cnt_q <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         rd_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= seq_busy;
         issue_cnt_q <= issue_cnt_d;
         sweep_cnt_q <= sweep_cnt_d;
         err_q       <= err_d;
         done_q      <= done_d;
         rd_cnt_q    <= rd_cnt_d;
      end
   end

   // Strobe index travels alongside the ADC pipeline so it meets its sample.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         for (int i = 0; i < ADC_LAT; i++) dl_vld_q[i] <= 1'b0;
         wr_vld_q <= 1'b0;
      end else begin
         dl_vld_q[0] <= push_sp;
         for (int i = 1; i < ADC_LAT; i++) dl_vld_q[i] <= dl_vld_q[i-1];
         wr_vld_q <= dl_vld_q[ADC_LAT-1];
      end
      dl_idx_q[0] <= issue_cnt_q[IW-1:0];
      for (int i = 1; i < ADC_LAT; i++) dl_idx_q[i] <= dl_idx_q[i-1];
      wr_idx_q <= dl_idx_q[ADC_LAT-1];
      wr_smp_q <= adc_data;
   end

   assign ram_we    = wr_vld_q;
   assign ram_waddr = wr_idx_q;
   assign ram_wdata = (sweep_cnt_q == '0) ? AW'(wr_smp_q) : ram_rdata + AW'(wr_smp_q);
   assign ram_raddr = (state_q == ST_READOUT) ? rd_cnt_q[IW-1:0] : dl_idx_q[ADC_LAT-1];

   ets_acc_ram #(
      .DEPTH (POINT_NUM),
      .W     (AW),
      .AW    (IW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   // Readout: a beat moves on any cycle with rd_valid && rd_ready; while rd_valid is
   // high and rd_ready low, rd_data/rd_last hold their value.
   assign rd_word = DATA_W'(ram_rdata >> AVG_LOG2);

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         cnt_q           <= 2'd0;
         wptr_q          <= 1'b0;
         rptr_q          <= 1'b0;
      end else begin
         inflight_q      <= rd_issue;
         inflight_last_q <= (rd_cnt_q[IW-1:0] == LAST_IDX);
         if (inflight_q) wptr_q <= ~wptr_q;
         if (pop) rptr_q <= ~rptr_q;
         cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fifo_data_q[0] <= '0;
         fifo_data_q[1] <= '0;
         fifo_last_q[0] <= 1'b0;
         fifo_last_q[1] <= 1'b0;
      end else if (inflight_q) begin
         fifo_data_q[wptr_q] <= rd_word;
         fifo_last_q[wptr_q] <= inflight_last_q;
      end
   end

   assign rd_valid  = (cnt_q != 2'd0);
   assign rd_data   = fifo_data_q[rptr_q];
   assign rd_last   = fifo_last_q[rptr_q];
   assign armed     = (state_q == ST_ARMED) || (state_q == ST_SWEEP) ||
                      (state_q == ST_GAP) || (state_q == ST_DRAIN);
   assign done      = done_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ets_capture.sv
// Self-checking bench for ets_capture: randomized sweeps against a per-point sum model.
module tb_ets_capture;
   import ets_pkg::*;

   localparam int DW   = 12;
   localparam int PN   = 256;
   localparam int LAT  = 3;
   localparam int AVGL = 2;

   logic          clk = 1'b0;
   logic          rst_n, start, abort, seq_busy, sp_en, rd_ready;
   logic [DW-1:0] adc_data, sp_val;
   logic          armed, done, err, rd_valid, rd_last;
   logic [DW-1:0] rd_data;
   ets_state_t    dbg_state;

   logic [DW-1:0] adc_pipe [LAT];
   logic [DW-1:0] sweep_vals [PN];
   int            model_acc [PN];
   logic [DW-1:0] exp_q [$];
   int            n_checks, n_pass;

   ets_capture #(
      .DATA_W    (DW),
      .POINT_NUM (PN),
      .ADC_LAT   (LAT),
      .AVG_LOG2  (AVGL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .seq_busy  (seq_busy),
      .sp_en     (sp_en),
      .adc_data  (adc_data),
      .armed     (armed),
      .done      (done),
      .err       (err),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .dbg_state (dbg_state)
   );

   // clock / ADC model: the word for a strobe appears LAT cycles later, noise otherwise
   always #5 clk = ~clk;

   always @(posedge clk) begin
      adc_pipe[0] <= sp_en ? sp_val : DW'($urandom);
      for (int i = 1; i < LAT; i++) adc_pipe[i] <= adc_pipe[i-1];
   end
   assign adc_data = adc_pipe[LAT-1];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic model_clear();
      for (int i = 0; i < PN; i++) model_acc[i] = 0;
   endtask

   task automatic fill_random();
      for (int i = 0; i < PN; i++) sweep_vals[i] = DW'($urandom);
   endtask

   task automatic fill_const(input int v);
      for (int i = 0; i < PN; i++) sweep_vals[i] = DW'(v);
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      n_checks++;
      if (armed !== 1'b0) $display("FAIL armed_pre_start: got %b want 0", armed);
      else n_pass++;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (armed !== 1'b1 || err !== 1'b0)
         $display("FAIL start_accept: armed=%b err=%b want armed=1 err=0", armed, err);
      else n_pass++;
      model_clear();
   endtask

   task automatic pulse_sp(input int n);
      for (int i = 0; i < n; i++) begin
         sp_en  = 1'b1;
         sp_val = DW'($urandom);
         @(negedge clk);
         sp_en = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic run_sweep(input int n_pts, input bit last_sweep);
      bit left;
      @(negedge clk);
      seq_busy = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < n_pts; i++) begin
         sp_en  = 1'b1;
         sp_val = sweep_vals[i];
         @(negedge clk);
         sp_en = 1'b0;
         if (i != n_pts - 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      if (n_pts == PN) begin
         for (int i = 0; i < PN; i++) model_acc[i] += int'(sweep_vals[i]);
         left = 1'b0;
         for (int c = 0; c < 64 && !left; c++) begin
            @(negedge clk);
            left = (dbg_state != ST_SWEEP) && (dbg_state != ST_DRAIN);
         end
         n_checks++;
         if (dbg_state !== (last_sweep ? ST_READOUT : ST_GAP))
            $display("FAIL sweep_end_state: got %0d want %0d", dbg_state,
                     last_sweep ? ST_READOUT : ST_GAP);
         else n_pass++;
         seq_busy = 1'b0;
      end
   endtask

   // scoreboard: drain one record, compare against the model, check handshake and done
   task automatic collect(input int ready_pct, input bit inject_start);
      int            beats, cyc, first_valid, bubbles;
      bit            hold, injected, got_last;
      logic [DW-1:0] hold_d, exp_w;
      logic          hold_l;
      for (int i = 0; i < PN; i++) exp_q.push_back(DW'(model_acc[i] >> AVGL));
      beats = 0; cyc = 0; first_valid = -1; bubbles = 0;
      hold = 1'b0; injected = 1'b0; got_last = 1'b0;
      hold_d = '0; hold_l = 1'b0;
      while (!got_last && cyc < 5000) begin
         start = 1'b0;
         if (hold) begin
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== hold_d || rd_last !== hold_l)
               $display("FAIL stall_hold: valid=%b data=%0d last=%b want valid=1 data=%0d last=%b",
                        rd_valid, rd_data, rd_last, hold_d, hold_l);
            else n_pass++;
         end
         if (first_valid < 0 && rd_valid === 1'b1) first_valid = cyc;
         rd_ready = ($urandom_range(0, 99) < ready_pct);
         if (inject_start && !injected && beats == 10) begin
            start    = 1'b1;
            injected = 1'b1;
         end
         if (rd_valid === 1'b1 && rd_ready) begin
            exp_w = exp_q.pop_front();
            n_checks++;
            if (rd_data !== exp_w) $display("FAIL rd_data[%0d]: got %0d want %0d", beats, rd_data, exp_w);
            else n_pass++;
            n_checks++;
            if (rd_last !== (beats == PN - 1))
               $display("FAIL rd_last[%0d]: got %b want %b", beats, rd_last, beats == PN - 1);
            else n_pass++;
            if (beats == PN - 1) begin
               n_checks++;
               if (done !== 1'b0) $display("FAIL done_early: got %b want 0", done);
               else n_pass++;
            end
            beats++;
            got_last = (beats == PN);
            hold     = 1'b0;
         end else if (rd_valid === 1'b1) begin
            hold   = 1'b1;
            hold_d = rd_data;
            hold_l = rd_last;
         end else begin
            hold = 1'b0;
            if (first_valid >= 0 && rd_ready) bubbles++;
         end
         @(negedge clk);
         cyc++;
      end
      rd_ready = 1'b0;
      start    = 1'b0;
      n_checks++;
      if (beats != PN) $display("FAIL beat_count: got %0d want %0d", beats, PN);
      else n_pass++;
      n_checks++;
      if (first_valid != 2) $display("FAIL valid_latency: got %0d want 2", first_valid);
      else n_pass++;
      if (ready_pct >= 100) begin
         n_checks++;
         if (bubbles != 0) $display("FAIL throughput_bubbles: got %0d want 0", bubbles);
         else n_pass++;
      end
      n_checks++;
      if (done !== 1'b1) $display("FAIL done_pulse: got %b want 1", done);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || dbg_state !== ST_IDLE || armed !== 1'b0 || rd_valid !== 1'b0)
         $display("FAIL post_done: done=%b state=%0d armed=%b valid=%b want 0/IDLE/0/0",
                  done, dbg_state, armed, rd_valid);
      else n_pass++;
      exp_q.delete();
   endtask

   task automatic quiet_check(input string name, input int n);
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rd_valid === 1'b1) seen++;
      end
      n_checks++;
      if (seen != 0) $display("FAIL %s: rd_valid high %0d cycles want 0", name, seen);
      else n_pass++;
   endtask

   // test scenarios
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
      n_checks++; if (armed !== 1'b0) $display("FAIL reset_armed: got %b want 0", armed); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
      n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rd_valid); else n_pass++;
      n_checks++; if (rd_data !== '0) $display("FAIL reset_data: got %0d want 0", rd_data); else n_pass++;
      n_checks++; if (rd_last !== 1'b0) $display("FAIL reset_last: got %b want 0", rd_last); else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_record();
      do_start();
      for (int k = 0; k < 4; k++) begin
         fill_random();
         run_sweep(PN, k == 3);
      end
      collect(100, 1'b0);
   endtask

   task automatic test_const_avg();
      do_start();
      for (int k = 0; k < 4; k++) begin
         fill_const(4095 - k);
         run_sweep(PN, k == 3);
      end
      collect(100, 1'b0);
   endtask

   task automatic test_stall();
      do_start();
      for (int k = 0; k < 4; k++) begin
         fill_random();
         run_sweep(PN, k == 3);
      end
      collect(30, 1'b0);
   endtask

   task automatic test_truncate();
      do_start();
      fill_random();
      run_sweep(100, 1'b0);
      seq_busy = 1'b0;
      @(negedge clk);
      n_checks++;
      if (err !== 1'b1 || dbg_state !== ST_IDLE || armed !== 1'b0)
         $display("FAIL truncate: err=%b state=%0d armed=%b want 1/IDLE/0", err, dbg_state, armed);
      else n_pass++;
      quiet_check("truncate_no_readout", 30);
      n_checks++;
      if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err);
      else n_pass++;
      do_start();
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if (dbg_state !== ST_IDLE) $display("FAIL abort_armed: state=%0d want IDLE", dbg_state);
      else n_pass++;
   endtask

   task automatic test_abort();
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      n_checks++;
      if (dbg_state !== ST_IDLE || armed !== 1'b0)
         $display("FAIL abort_beats_start: state=%0d armed=%b want IDLE/0", dbg_state, armed);
      else n_pass++;
      do_start();
      for (int k = 0; k < 2; k++) begin
         fill_random();
         run_sweep(PN, 1'b0);
      end
      fill_random();
      run_sweep(80, 1'b0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if (dbg_state !== ST_IDLE || armed !== 1'b0 || rd_valid !== 1'b0 || err !== 1'b0)
         $display("FAIL abort_sweep: state=%0d armed=%b valid=%b err=%b want IDLE/0/0/0",
                  dbg_state, armed, rd_valid, err);
      else n_pass++;
      seq_busy = 1'b0;
      quiet_check("abort_no_readout", 20);
      do_start();
      for (int k = 0; k < 4; k++) begin
         fill_random();
         run_sweep(PN, k == 3);
      end
      collect(70, 1'b0);
   endtask

   task automatic test_ignore();
      pulse_sp(5);
      n_checks++;
      if (dbg_state !== ST_IDLE) $display("FAIL idle_sp_en: state=%0d want IDLE", dbg_state);
      else n_pass++;
      do_start();
      fill_random();
      run_sweep(PN, 1'b0);
      pulse_sp(6);
      n_checks++;
      if (dbg_state !== ST_GAP) $display("FAIL gap_sp_en: state=%0d want GAP", dbg_state);
      else n_pass++;
      for (int k = 1; k < 4; k++) begin
         fill_random();
         run_sweep(PN, k == 3);
      end
      collect(100, 1'b1);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      seq_busy = 1'b0;
      sp_en    = 1'b0;
      sp_val   = '0;
      rd_ready = 1'b0;
      test_reset();
      test_single_record();
      test_const_avg();
      test_stall();
      test_truncate();
      test_abort();
      test_ignore();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ets_capture.md
# ets_capture

Capture-and-average stage directly downstream of the equivalent-time sampling sequencer. Each sampling strobe from the sequencer latches one ADC word, after a fixed ADC pipeline delay, into a per-point accumulator. The block averages 2^AVG_LOG2 consecutive triggered sweeps of POINT_NUM points each, then streams the averaged record out over a valid/ready interface.

## Interface
- DATA_W, 12: ADC sample width.
- POINT_NUM, 256: points per sweep; must equal the sequencer's point count; power of two.
- ADC_LAT, 3: cycles from `sp_en` to the matching `adc_data` word; range 1..15.
- AVG_LOG2, 2: log2 of sweeps averaged; range 0..4.
- clk  in  1  capture clock (200 MHz), shared with the sequencer.
- rst_n  in  1  reset: synchronous, active-low; clock clk.
- start  in  1  one-cycle arm request from the host.
- abort  in  1  one-cycle cancel; discards the record.
- seq_busy  in  1  sequencer busy; high for the duration of one sweep.
- sp_en  in  1  sequencer sampling strobe; one point per pulse.
- adc_data  in  DATA_W  ADC output word.
- armed  out  1  high from the accepted `start` until readout begins.
- done  out  1  one-cycle pulse after the last readout beat.
- err  out  1  sticky sweep-truncation flag; cleared by the next accepted `start`.
- rd_valid  out  1  readout word valid.
- rd_ready  in  1  downstream accept.
- rd_data  out  DATA_W  averaged point: accumulated sum >> AVG_LOG2, truncated.
- rd_last  out  1  high with the POINT_NUM-1 word.

## Operation
- FSM states: IDLE, ARMED, SWEEP, GAP, DRAIN, READOUT.
- IDLE, `start` -> ARMED. Clears `err` and the sweep counter. `start` in any other state is ignored.
- ARMED or GAP, `seq_busy` rising -> SWEEP. The issue counter resets to 0.
- SWEEP, each `sp_en`: push the issue index into an ADC_LAT-deep delay line and increment the issue counter. When the issue counter reaches POINT_NUM, stop accepting `sp_en`.
- Delayed strobe with index i: read acc[i].
  - Next cycle, write adc_data_delayed to acc[i] if the sweep counter is 0; otherwise write acc[i] + adc_data_delayed.
  - Accumulator width: DATA_W+AVG_LOG2; the sum never wraps.
- Sweep completion is the write of index POINT_NUM-1, not `seq_busy` falling.
  - At completion, increment the sweep counter.
  - If the sweep counter equals 2^AVG_LOG2, go to READOUT; otherwise go to GAP.
- `seq_busy` falls in SWEEP with issue count < POINT_NUM: set `err`, flush the delay line, go to IDLE.
- `sp_en` outside SWEEP (IDLE, ARMED, GAP, READOUT) is ignored and nothing is written.
- READOUT: stream acc[0..POINT_NUM-1] in order, then pulse `done` and go to IDLE.
- `abort` in any state: go to IDLE next cycle, flush the delay line, drop `rd_valid` and `armed`. `err` is unchanged.
- `abort` and `start` in the same cycle: `abort` wins.
- DRAIN is entered from SWEEP after the last `sp_en` is issued. It waits for the delay line to empty before the completion check.

## Timing
- Reset values: FSM IDLE, `armed`=0, `done`=0, `err`=0, `rd_valid`=0, `rd_data`=0, `rd_last`=0. Accumulator contents are undefined and are not cleared.
- `armed` rises the cycle after `start` is accepted.
- Capture latency: `adc_data` sampled ADC_LAT cycles after `sp_en`; RAM write 1 cycle later.
- `sp_en` spacing ≥ 2 cycles is supported without hazard. Spacing of 1 is not supported.
- `rd_valid` asserts 2 cycles after READOUT entry.
- Readout handshake:
  - Beat transfers when `rd_valid` && `rd_ready`.
  - Throughput is 1 beat per cycle with `rd_ready` held high.
  - `rd_data` and `rd_last` are held stable while `rd_valid` && !`rd_ready`.
- `done` pulses the cycle after the `rd_last` beat transfers.

## Structure
- Package `ets_pkg`:
  - state enum `ets_state_t`;
  - accumulator width function `acc_w(DATA_W, AVG_LOG2)`;
  - index width `$clog2(POINT_NUM)`.
- Sub-module `ets_acc_ram`: simple dual-port RAM, POINT_NUM × acc_w, 1 write port, 1 read port with 1-cycle registered read.
  - The read port is shared between RMW and READOUT by the FSM.
- The readout path uses a 2-entry skid buffer to sustain full throughput across the RAM read latency.

## Test plan
- AVG_LOG2=0, one sweep, adc_data = index (sp_en every 200+i cycles) -> readout 0..255 in order, `rd_last` on word 255, `done` 1 cycle later.
- AVG_LOG2=2, four sweeps, sweep k drives adc_data = 4095−k -> every word = (4095+4094+4093+4092)>>2 = 4093.
- Random `rd_ready` at 30% duty -> 256 beats, no drop or duplicate, data stable while stalled.
- `seq_busy` falls after 100 `sp_en` -> `err`=1, state IDLE, no readout. Next `start` clears `err`.
- `abort` during the 3rd sweep -> IDLE next cycle, `armed`=0, no `rd_valid`. A subsequent `start` followed by 4 sweeps gives a correct average.
- `sp_en` pulses in IDLE and GAP, and `start` during READOUT -> ignored, output record unchanged.
